// File: rtl/spi_master_param.sv
// Parametrised SPI master: all four CPOL/CPHA modes, 1..NUM_WORDS words per transfer,
// tick-based SCLK generation and programmable CS setup/hold; fully synchronous to i_clock.
module spi_master_param #(
  parameter int unsigned WORD_WIDTH = 8,
  parameter int unsigned NUM_WORDS  = 2,
  parameter int unsigned LEN_W      = 2,
  parameter int unsigned CLK_DIV    = 25,
  parameter int unsigned CS_SETUP   = 2,
  parameter int unsigned CS_HOLD    = 1
) (
  input  logic                            i_clock,
  input  logic                            i_reset,
  input  logic                            i_enable,
  input  logic                            i_start,
  input  logic [1:0]                      i_mode,
  input  logic [LEN_W-1:0]                i_num_words,
  input  logic [NUM_WORDS*WORD_WIDTH-1:0] i_tx_data,
  output logic [NUM_WORDS*WORD_WIDTH-1:0] o_rx_data,
  output logic                            o_ready,
  output logic                            o_busy,
  output logic                            o_done,
  output logic                            o_sclk,
  output logic                            o_mosi,
  input  logic                            i_miso,
  output logic                            o_cs_n
);

  localparam int unsigned TotalBits = NUM_WORDS * WORD_WIDTH;
  localparam int unsigned MaxEdges  = 2 * TotalBits;
  localparam int unsigned MaxPhase  = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int unsigned MaxCnt    = (MaxEdges > MaxPhase) ? MaxEdges : MaxPhase;
  localparam int unsigned CntW      = $clog2(MaxCnt + 1);
  localparam int unsigned DivW      = $clog2(CLK_DIV);

  typedef enum logic [2:0] {StIdle, StSetup, StXfer, StHold, StGap} state_e;

  state_e                state_q, state_d;
  logic [DivW-1:0]       div_q, div_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [CntW-1:0]       edges_q, edges_d;
  logic [1:0]            mode_q, mode_d;
  logic [TotalBits-1:0]  tx_q, tx_d;
  logic [TotalBits-1:0]  rxsh_q, rxsh_d;
  logic [TotalBits-1:0]  rx_q, rx_d;
  logic                  sclk_q, sclk_d;
  logic                  mosi_q, mosi_d;
  logic                  cs_n_q, cs_n_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  tick;
  logic                  accept;
  logic                  leading;
  logic                  last_edge;
  int unsigned           n_words;
  logic [TotalBits-1:0]  aligned;

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    edges_d   = edges_q;
    mode_d    = mode_q;
    tx_d      = tx_q;
    rxsh_d    = rxsh_q;
    rx_d      = rx_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    done_d    = 1'b0;
    accept    = 1'b0;
    tick      = (state_q != StIdle) && (div_q == DivW'(CLK_DIV - 1));
    leading   = ~cnt_q[0];
    last_edge = (cnt_q == edges_q - CntW'(1));

    n_words = 32'(i_num_words);
    if (n_words == 0) begin
      n_words = 1;
    end else if (n_words > NUM_WORDS) begin
      n_words = NUM_WORDS;
    end
    // Left-justify the active bits so MOSI always shifts out of the top bit.
    aligned = i_tx_data << ((NUM_WORDS - n_words) * WORD_WIDTH);

    if (state_q != StIdle) begin
      div_d = tick ? '0 : div_q + DivW'(1);
    end

    if ((state_q != StIdle) && !i_enable) begin
      state_d = StIdle;
      sclk_d  = mode_q[1];
      div_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          sclk_d = i_mode[1];
          if (i_start && ready_q) begin
            accept  = 1'b1;
            state_d = StSetup;
            div_d   = '0;
            cnt_d   = '0;
            mode_d  = i_mode;
            edges_d = CntW'(2 * n_words * WORD_WIDTH);
            rxsh_d  = '0;
            if (!i_mode[0]) begin
              mosi_d = aligned[TotalBits-1];
              tx_d   = aligned << 1;
            end else begin
              tx_d   = aligned;
            end
          end
        end
        StSetup: begin
          if (tick) begin
            if (cnt_q == CntW'(CS_SETUP - 1)) begin
              state_d = StXfer;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CntW'(1);
            end
          end
        end
        StXfer: begin
          if (tick) begin
            sclk_d = ~sclk_q;
            cnt_d  = cnt_q + CntW'(1);
            // CPHA selects whether the leading or trailing edge is the sampling edge.
            if (leading ^ mode_q[0]) begin
              rxsh_d = {rxsh_q[TotalBits-2:0], i_miso};
            end else if (leading || !last_edge) begin
              mosi_d = tx_q[TotalBits-1];
              tx_d   = tx_q << 1;
            end
            if (last_edge) begin
              state_d = StHold;
              cnt_d   = '0;
            end
          end
        end
        StHold: begin
          if (tick) begin
            if (cnt_q == CntW'(CS_HOLD - 1)) begin
              state_d = StGap;
              cnt_d   = '0;
              done_d  = 1'b1;
              rx_d    = rxsh_q;
            end else begin
              cnt_d = cnt_q + CntW'(1);
            end
          end
        end
        StGap: begin
          if (tick) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    ready_d = (state_q == StIdle) && i_enable && !accept;
    busy_d  = (state_d != StIdle);
    cs_n_d  = (state_d == StIdle) || (state_d == StGap);
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= StIdle;
      div_q   <= '0;
      cnt_q   <= '0;
      edges_q <= '0;
      mode_q  <= '0;
      tx_q    <= '0;
      rxsh_q  <= '0;
      rx_q    <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      edges_q <= edges_d;
      mode_q  <= mode_d;
      tx_q    <= tx_d;
      rxsh_q  <= rxsh_d;
      rx_q    <= rx_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      cs_n_q  <= cs_n_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o_rx_data = rx_q;
  assign o_ready   = ready_q;
  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_sclk    = sclk_q;
  assign o_mosi    = mosi_q;
  assign o_cs_n    = cs_n_q;

endmodule

// File: doc/spi_master_param.md
Name: spi_master_param

Overview:
- Parametrised SPI master; next generation of the fixed 16-bit, mode-0 SLM-driver SPI block.
- Fully synchronous to i_clock. SCLK is generated by a clock-enable tick counter, not a derived clock.
- Adds all four CPOL/CPHA modes, variable transfer length of 1..NUM_WORDS words, a ready/start handshake, programmable CS setup/hold, and abort on disable.
- Sits between register-access controllers (HDP-1280-2 configuration, future peripherals) and the SPI pins.

Parameters:
- WORD_WIDTH, 8, bits per word.
- NUM_WORDS, 2, maximum words per transfer; shift-register width is NUM_WORDS*WORD_WIDTH.
- LEN_W, 2, width of i_num_words; must be able to encode NUM_WORDS.
- CLK_DIV, 25, i_clock cycles per SCLK half-period ("tick"); must be >= 2. At 50 MHz this gives 1 MHz SCLK.
- CS_SETUP, 2, ticks from CS_n falling to the first SCLK edge; must be >= 1.
- CS_HOLD, 1, ticks from the last SCLK edge to CS_n rising; must be >= 1.

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_enable  in  1  block enable; low aborts any transfer in progress.
- i_start  in  1  transfer request; accepted on the cycle where i_start && o_ready.
- i_mode  in  2  {CPOL, CPHA}; latched on accept.
- i_num_words  in  LEN_W  words to transfer; latched on accept.
- i_tx_data  in  NUM_WORDS*WORD_WIDTH  transmit data, right-justified; latched on accept.
- o_rx_data  out  NUM_WORDS*WORD_WIDTH  receive data, right-justified, upper bits zero.
- o_ready  out  1  idle and able to accept a request.
- o_busy  out  1  transfer in progress.
- o_done  out  1  one-cycle pulse when o_rx_data updates.
- o_sclk  out  1  SPI clock.
- o_mosi  out  1  SPI data out.
- i_miso  in  1  SPI data in.
- o_cs_n  out  1  chip select, active low.

Behaviour:
- Reset values: o_cs_n=1, o_sclk=0, o_mosi=0, o_rx_data=0, o_ready=0, o_busy=0, o_done=0. State=IDLE, divider=0.
- All outputs are registered; no combinational path from inputs to the SPI pins.
- Length: N = clamp(i_num_words) to 1..NUM_WORDS (0 is treated as 1). Transmit i_tx_data[N*W-1:0] MSB first, where W=WORD_WIDTH.
- Divider: reset to 0 on accept. A tick fires every CLK_DIV i_clock cycles while not IDLE.
- IDLE:
  - o_cs_n=1, o_sclk=registered i_mode[1], o_ready=i_enable registered.
  - On accept: latch mode, N and tx data, o_ready=0, o_busy=1, go to SETUP.
- SETUP:
  - o_cs_n=0, o_sclk=CPOL.
  - If CPHA=0, o_mosi=first bit on entry.
  - After CS_SETUP ticks go to XFER.
- XFER:
  - 2*N*W ticks; each tick toggles o_sclk. Odd ticks are leading edges, even ticks are trailing edges.
  - CPHA=0: sample i_miso on the leading edge; shift o_mosi on the trailing edge, except the final one.
  - CPHA=1: shift o_mosi on the leading edge (first bit on the first leading edge); sample on the trailing edge.
  - Sampling registers i_miso on the same i_clock cycle as the sampling SCLK edge.
- HOLD:
  - o_sclk=CPOL, o_cs_n=0, o_mosi holds.
  - After CS_HOLD ticks: o_rx_data <= received N*W bits right-justified (upper bits 0), o_done=1 for one cycle, o_cs_n=1, go to GAP.
- GAP: CS_n high for 1 tick minimum, o_busy=1, o_ready=0; then IDLE.
- Latency: o_done asserts exactly CLK_DIV*(CS_SETUP+2*N*W+CS_HOLD) cycles after the accept edge. o_ready returns CLK_DIV+1 cycles after o_done.
- i_start while not ready: ignored, no queuing. i_start held high: a new transfer is accepted when o_ready returns.
- i_mode/i_tx_data/i_num_words changing mid-transfer: no effect.
- i_enable low in any non-IDLE state:
  - Next cycle: o_cs_n=1, o_sclk=CPOL, o_busy=0, state IDLE.
  - No o_done; o_rx_data unchanged.
- i_enable low in IDLE: o_ready=0 and requests are ignored.
- i_reset mid-transfer: immediate reset values; no o_done.
- o_sclk never toggles while o_cs_n=1. o_cs_n has no glitches: exactly one fall and one rise per transfer.

Test Plan:
- Test configuration: CLK_DIV=4, CS_SETUP=2, CS_HOLD=1, W=8, NUM_WORDS=2.
- Mode 0, N=2, tx=16'hA55A, slave model returns 16'h3CC3 → MOSI shows A55A MSB first, sampled on rising edges; 16 SCLK pulses; o_rx_data=16'h3CC3; o_done exactly 140 cycles after accept.
- Modes 1, 2, 3 with the same data → idle SCLK level equals CPOL; slave models of the matching mode receive 16'hA55A and return 16'h3CC3 correctly.
- N=1, tx=16'hFF81 → only 8'h81 is sent; 8 pulses; o_rx_data=16'h00xx; o_done at 4*(2+16+1)=76 cycles. N=0 behaves identically to N=1.
- Enable dropped at SCLK pulse 5 → CS_n high next cycle, no o_done, o_rx_data keeps its previous value; a following transfer completes normally.
- Back-to-back: i_start held high → second CS_n fall occurs >= 4 cycles after the first rise; i_start while busy is ignored. i_reset pulsed mid-XFER → all outputs return to reset values immediately.
